// File: rtl/psum_accumulator_if.sv
// ----------------------------------------------------------------------------
// psum_accumulator_if
//  Bundles the job-configuration, partial-sum beat and result handshake
//  signals of psum_accumulator.
//  master : job/beat source and result consumer
//           (drives cfg_*, psum_*, acc_ready)
//  slave  : the accumulator
//           (drives acc_valid, acc_out, busy, err, sat)
//  Signals:
//    cfg_valid/cfg_num_chunks         job start strobe and beat count
//    psum_valid/psum0/psum1           partial-sum beat, two signed lanes
//    acc_valid/acc_ready/acc_out      result handshake and signed result
//    busy/err/sat                     status flags
// ----------------------------------------------------------------------------
interface psum_accumulator_if #(
   parameter int unsigned PSUM_WIDTH = 32,
   parameter int unsigned ACC_WIDTH  = 48,
   parameter int unsigned CNT_WIDTH  = 16
);
   logic                         cfg_valid;
   logic        [CNT_WIDTH-1:0]  cfg_num_chunks;
   logic                         psum_valid;
   logic signed [PSUM_WIDTH-1:0] psum0;
   logic signed [PSUM_WIDTH-1:0] psum1;
   logic                         acc_valid;
   logic                         acc_ready;
   logic signed [ACC_WIDTH-1:0]  acc_out;
   logic                         busy;
   logic                         err;
   logic                         sat;

   modport master (
      output cfg_valid, cfg_num_chunks, psum_valid, psum0, psum1, acc_ready,
      input  acc_valid, acc_out, busy, err, sat
   );

   modport slave (
      input  cfg_valid, cfg_num_chunks, psum_valid, psum0, psum1, acc_ready,
      output acc_valid, acc_out, busy, err, sat
   );
endinterface

// File: rtl/psum_accumulator.sv
// ----------------------------------------------------------------------------
// psum_accumulator
//  Sums both signed partial-sum lanes over a configured number of beats and
//  presents the wide result on a valid/ready handshake. Beats cannot be
//  back-pressured; beats arriving outside a job are dropped and flagged.
//  Ports:
//    clk     clock, all logic on posedge
//    resetn  synchronous active-low reset
//    bus     psum_accumulator_if.slave (cfg, psum beats, result, status)
//  Optional feature macro: ACC_SAT_EN
//    defined   : every add saturates to the signed ACC_WIDTH range and sets
//                the sticky sat flag on overflow
//    undefined : adds wrap modulo 2^ACC_WIDTH, sat is tied 0
// ----------------------------------------------------------------------------
module psum_accumulator #(
   parameter int unsigned PSUM_WIDTH = 32,
   parameter int unsigned ACC_WIDTH  = 48,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input logic               clk,
   input logic               resetn,
   psum_accumulator_if.slave bus
);

   // Lane sum keeps one guard bit so psum0+psum1 can never overflow.
   localparam int unsigned LANE_W = PSUM_WIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   state_e                      state_q,     state_d;
   logic signed [ACC_WIDTH-1:0] acc_q,       acc_d;
   logic        [CNT_WIDTH-1:0] cnt_q,       cnt_d;
   logic        [CNT_WIDTH-1:0] n_q,         n_d;
   logic                        err_q,       err_d;
   logic                        acc_valid_q, acc_valid_d;
   logic                        busy_q,      busy_d;

   logic signed [LANE_W-1:0]    lane_sum_c;
   logic signed [ACC_WIDTH-1:0] add_c;
   logic                        ovf_c;
   logic                        cfg_legal_c;

   // Sign-extended lane sum formed at PSUM_WIDTH+1 bits.
   always_comb begin
      lane_sum_c = LANE_W'(bus.psum0) + LANE_W'(bus.psum1);
   end

`ifdef ACC_SAT_EN
   localparam int unsigned SUM_W = ACC_WIDTH + 1;
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   logic signed [SUM_W-1:0] sum_c;
   logic                    sat_q, sat_d;

   // Overflow shows up as disagreement between the two top bits of the
   // one-bit-wider sum; the top bit then gives the clamp direction.
   always_comb begin
      sum_c = SUM_W'(acc_q) + SUM_W'(lane_sum_c);
      ovf_c = sum_c[SUM_W-1] ^ sum_c[SUM_W-2];
      if (ovf_c) begin
         add_c = sum_c[SUM_W-1] ? ACC_MIN : ACC_MAX;
      end else begin
         add_c = sum_c[ACC_WIDTH-1:0];
      end
   end

   assign bus.sat = sat_q;
`else
   // Plain modulo-2^ACC_WIDTH add.
   always_comb begin
      ovf_c = 1'b0;
      add_c = acc_q + ACC_WIDTH'(lane_sum_c);
   end

   assign bus.sat = 1'b0;
`endif

   assign cfg_legal_c = (bus.cfg_num_chunks != '0);

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         n_q         <= '0;
         err_q       <= 1'b0;
         acc_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         err_q       <= err_d;
         acc_valid_q <= acc_valid_d;
         busy_q      <= busy_d;
      end
   end

`ifdef ACC_SAT_EN
   // Sticky saturation flag.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sat_q <= 1'b0;
      end else begin
         sat_q <= sat_d;
      end
   end
`endif

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      n_d         = n_q;
      err_d       = err_q;
`ifdef ACC_SAT_EN
      sat_d       = sat_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (bus.psum_valid) begin
               err_d = 1'b1;
            end
            if (bus.cfg_valid) begin
               if (cfg_legal_c) begin
                  n_d     = bus.cfg_num_chunks;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = ST_ACCUM;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         // cfg_valid is deliberately ignored while a job is running.
         ST_ACCUM: begin
            if (bus.psum_valid) begin
               acc_d = add_c;
               cnt_d = cnt_q + CNT_WIDTH'(1);
`ifdef ACC_SAT_EN
               if (ovf_c) begin
                  sat_d = 1'b1;
               end
`endif
               if (cnt_d == n_q) begin
                  state_d = ST_HOLD;
               end
            end
         end

         // Result held; a legal cfg together with acc_ready restarts with
         // no idle bubble.
         ST_HOLD: begin
            if (bus.psum_valid) begin
               err_d = 1'b1;
            end
            if (bus.acc_ready) begin
               state_d = ST_IDLE;
               if (bus.cfg_valid) begin
                  if (cfg_legal_c) begin
                     n_d     = bus.cfg_num_chunks;
                     acc_d   = '0;
                     cnt_d   = '0;
                     state_d = ST_ACCUM;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      acc_valid_d = (state_d == ST_HOLD);
      busy_d      = (state_d != ST_IDLE);
   end

   assign bus.acc_valid = acc_valid_q;
   assign bus.acc_out   = acc_q;
   assign bus.busy      = busy_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// ----------------------------------------------------------------------------
// tb_psum_accumulator
//  Self-checking bench for psum_accumulator (ACC_WIDTH=34 so the overflow
//  case is reachable with 32-bit lanes). Directed job table, hand-written
//  multi-cycle sequences, then random jobs against an arithmetic model.
// ----------------------------------------------------------------------------
module tb_psum_accumulator;

   localparam int unsigned PW = 32;
   localparam int unsigned AW = 34;
   localparam int unsigned CW = 16;
   localparam longint ACC_MAX = (64'sd1 <<< (AW - 1)) - 1;
   localparam longint ACC_MIN = -(64'sd1 <<< (AW - 1));

   logic clk;
   logic resetn;

   psum_accumulator_if #(.PSUM_WIDTH(PW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

   psum_accumulator #(.PSUM_WIDTH(PW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;
   bit exp_err;
   bit exp_sat;

   typedef struct {
      int unsigned    n;
      logic [3:0][31:0] p0;
      logic [3:0][31:0] p1;
      longint         exp_acc;
      bit             exp_sat;
   } vec_t;

   vec_t vecs [5];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic start_job(input int unsigned n);
      bus.cfg_valid      = 1'b1;
      bus.cfg_num_chunks = CW'(n);
      step();
      bus.cfg_valid      = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] p0, input logic [31:0] p1);
      bus.psum_valid = 1'b1;
      bus.psum0      = p0;
      bus.psum1      = p1;
      step();
      bus.psum_valid = 1'b0;
   endtask

   task automatic accept();
      bus.acc_ready = 1'b1;
      step();
      bus.acc_ready = 1'b0;
      check("accept_valid_drop", 64'(bus.acc_valid), 0);
      check("accept_busy_drop", 64'(bus.busy), 0);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      exp_err = 1'b0;
      exp_sat = 1'b0;
   endtask

   // One add of a beat onto the running value, clamped or wrapped.
   function automatic longint model_add(input longint acc, input int p0,
                                        input int p1, inout bit sat_flag);
      longint s;
      s = acc + longint'(p0) + longint'(p1);
`ifdef ACC_SAT_EN
      if (s > ACC_MAX) begin s = ACC_MAX; sat_flag = 1'b1; end
      if (s < ACC_MIN) begin s = ACC_MIN; sat_flag = 1'b1; end
`else
      s = s & ((64'sd1 <<< AW) - 1);
      if (s > ACC_MAX) s = s - (64'sd1 <<< AW);
`endif
      return s;
   endfunction

   initial begin
      longint exp_acc;
      total = 0;
      bad   = 0;
      bus.cfg_valid      = 1'b0;
      bus.cfg_num_chunks = '0;
      bus.psum_valid     = 1'b0;
      bus.psum0          = '0;
      bus.psum1          = '0;
      bus.acc_ready      = 1'b0;

      // Directed job table: expected results are hand-computed.
      vecs[0].n = 4; vecs[0].p0 = {32'd1, 32'd100, -32'sd5, 32'd10};
      vecs[0].p1 = {32'd1, 32'd0, 32'd5, 32'd20}; vecs[0].exp_acc = 132; vecs[0].exp_sat = 0;
      vecs[1].n = 1; vecs[1].p0 = {96'd0, 32'd3};
      vecs[1].p1 = {96'd0, -32'sd4}; vecs[1].exp_acc = -1; vecs[1].exp_sat = 0;
      vecs[2].n = 2; vecs[2].p0 = {64'd0, 32'd500, -32'sd1000};
      vecs[2].p1 = {64'd0, -32'sd1, -32'sd2000}; vecs[2].exp_acc = -2501; vecs[2].exp_sat = 0;
      vecs[3].n = 1; vecs[3].p0 = {96'd0, 32'd5};
      vecs[3].p1 = {96'd0, 32'd5}; vecs[3].exp_acc = 10; vecs[3].exp_sat = 0;
      vecs[4].n = 3; vecs[4].p0 = {4{32'h7FFF_FFFF}}; vecs[4].p1 = {4{32'h7FFF_FFFF}};
`ifdef ACC_SAT_EN
      vecs[4].exp_acc = 64'sh1_FFFF_FFFF; vecs[4].exp_sat = 1;
`else
      vecs[4].exp_acc = -(64'sd1 <<< 32) - 6; vecs[4].exp_sat = 0;
`endif

      // Reset state.
      resetn = 1'b0;
      step();
      step();
      check("rst_acc_valid", 64'(bus.acc_valid), 0);
      check("rst_acc_out", 64'(bus.acc_out), 0);
      check("rst_busy", 64'(bus.busy), 0);
      check("rst_err", 64'(bus.err), 0);
      check("rst_sat", 64'(bus.sat), 0);
      resetn = 1'b1;
      step();

      // Table jobs, latency 1 clk after the final beat.
      for (int i = 0; i < 5; i++) begin
         start_job(vecs[i].n);
         check("tbl_busy", 64'(bus.busy), 1);
         for (int b = 0; b < int'(vecs[i].n); b++) begin
            send_beat(vecs[i].p0[b], vecs[i].p1[b]);
            check("tbl_valid", 64'(bus.acc_valid), (b == int'(vecs[i].n) - 1) ? 1 : 0);
         end
         check("tbl_acc_out", 64'(bus.acc_out), vecs[i].exp_acc);
         check("tbl_sat", 64'(bus.sat), 64'(vecs[i].exp_sat));
         check("tbl_err", 64'(bus.err), 0);
         accept();
      end

      // T2: hold result with stray beat.
      start_job(4);
      send_beat(32'd10, 32'd20); send_beat(-32'sd5, 32'd5);
      send_beat(32'd100, 32'd0); send_beat(32'd1, 32'd1);
      for (int k = 0; k < 5; k++) begin
         if (k == 2) send_beat(32'd7, 32'd7);
         else step();
         check("t2_valid", 64'(bus.acc_valid), 1);
         check("t2_acc_out", 64'(bus.acc_out), 132);
      end
      check("t2_err", 64'(bus.err), 1);
      accept();

      // T5: reset mid-job.
      start_job(4);
      send_beat(32'd9, 32'd9); send_beat(32'd9, 32'd9);
      do_reset();
      check("t5_valid", 64'(bus.acc_valid), 0);
      check("t5_busy", 64'(bus.busy), 0);
      check("t5_acc_out", 64'(bus.acc_out), 0);
      check("t5_err", 64'(bus.err), 0);
      start_job(1);
      send_beat(32'd5, 32'd5);
      check("t5_result", 64'(bus.acc_out), 10);
      accept();

      // T3: illegal cfg then a legal job.
      start_job(0);
      check("t3_err", 64'(bus.err), 1);
      check("t3_busy", 64'(bus.busy), 0);
      step();
      check("t3_busy_idle", 64'(bus.busy), 0);
      start_job(1);
      send_beat(32'd3, -32'sd4);
      check("t3_valid", 64'(bus.acc_valid), 1);
      check("t3_result", 64'(bus.acc_out), -1);
      accept();

      // T6: accept and restart in the same cycle.
      start_job(4);
      send_beat(32'd10, 32'd20); send_beat(-32'sd5, 32'd5);
      send_beat(32'd100, 32'd0); send_beat(32'd1, 32'd1);
      check("t6_first", 64'(bus.acc_out), 132);
      bus.acc_ready = 1'b1;
      start_job(2);
      bus.acc_ready = 1'b0;
      check("t6_busy", 64'(bus.busy), 1);
      check("t6_valid_low", 64'(bus.acc_valid), 0);
      send_beat(32'd1, 32'd2);
      check("t6_mid_valid", 64'(bus.acc_valid), 0);
      send_beat(32'd3, 32'd4);
      check("t6_valid", 64'(bus.acc_valid), 1);
      check("t6_result", 64'(bus.acc_out), 10);
      accept();

      // Random jobs against the arithmetic model.
      do_reset();
      for (int j = 0; j < 40; j++) begin
         int unsigned n;
         int p0, p1;
         bit wide;
         n    = $urandom_range(1, 6);
         wide = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 3) == 0) begin
            send_beat($urandom, $urandom);
            exp_err = 1'b1;
         end
         start_job(n);
         exp_acc = 0;
         for (int b = 0; b < int'(n); b++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
               bus.cfg_valid      = ($urandom_range(0, 2) == 0);
               bus.cfg_num_chunks = CW'($urandom_range(0, 9));
               step();
               bus.cfg_valid = 1'b0;
            end
            if (wide) begin
               p0 = int'($urandom);
               p1 = int'($urandom);
            end else begin
               p0 = int'($urandom_range(0, 2000)) - 1000;
               p1 = int'($urandom_range(0, 2000)) - 1000;
            end
            exp_acc = model_add(exp_acc, p0, p1, exp_sat);
            send_beat(32'(p0), 32'(p1));
         end
         check("rnd_valid", 64'(bus.acc_valid), 1);
         check("rnd_acc_out", 64'(bus.acc_out), exp_acc);
         for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
            if ($urandom_range(0, 2) == 0) begin
               send_beat($urandom, $urandom);
               exp_err = 1'b1;
            end else begin
               step();
            end
            check("rnd_hold_out", 64'(bus.acc_out), exp_acc);
         end
         check("rnd_sat", 64'(bus.sat), 64'(exp_sat));
         check("rnd_err", 64'(bus.err), 64'(exp_err));
         accept();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
